// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the
// multicycle core (port 0) and a DMA/debug loader (port 1). Ownership is
// registered; contention is resolved round-robin, with a hold limit so a
// continuously requesting owner cannot starve the other port. Memory reads
// are combinational and writes commit on the clock edge ending a grant.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int HOLDMAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  // port 0: CPU
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] wd0,
  output logic             gnt0,
  output logic             stall0,
  output logic [WIDTH-1:0] rd0,
  // port 1: DMA / debug loader
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] wd1,
  output logic             gnt1,
  output logic             stall1,
  output logic [WIDTH-1:0] rd1,
  // memory side
  output logic [WIDTH-1:0] memadr,
  output logic [WIDTH-1:0] memwd,
  output logic             memwe,
  input  logic [WIDTH-1:0] memrd
);

  // Hold counter wide enough to reach HOLDMAX-1 with headroom to saturate.
  localparam int CW = $clog2(HOLDMAX) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(HOLDMAX - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  // Owner encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    r_owner;
  logic [CW-1:0] r_cnt;
  logic          r_last;   // port that most recently handed over ownership

  logic [1:0]    w_owner_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_last_next;
  logic [CW-1:0] w_cnt_inc;

  logic [1:0]    w_req;
  logic [1:0]    w_we;
  logic [1:0]    w_gnt;
  logic [1:0]    w_stall;
  logic [1:0]    w_own_match;

  assign w_req = {req1, req0};
  assign w_we  = {we1, we0};

  // Which port the registered owner state selects.
  assign w_own_match[0] = (r_owner == OWN0);
  assign w_own_match[1] = (r_owner == OWN1);

  // Per-port grant and stall; grants are masked during reset so nothing
  // reaches memory while the arbiter is being cleared.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign w_gnt[gi]   = w_own_match[gi] & w_req[gi] & ~reset;
      assign w_stall[gi] = w_req[gi] & ~w_gnt[gi];
    end
  endgenerate

  assign gnt0   = w_gnt[0];
  assign gnt1   = w_gnt[1];
  assign stall0 = w_stall[0];
  assign stall1 = w_stall[1];

  // Read data is simply broadcast; each requester qualifies it with its grant.
  assign rd0 = memrd;
  assign rd1 = memrd;

  // Route the granted port's address/data to memory; zero when nobody owns it.
  always_comb begin
    memadr = '0;
    memwd  = '0;
    if (w_gnt[0]) begin
      memadr = adr0;
      memwd  = wd0;
    end else if (w_gnt[1]) begin
      memadr = adr1;
      memwd  = wd1;
    end
  end

  // Write strobe: only the granted port's we, and never while in reset
  // (covers reset landing in the middle of a write cycle).
  assign memwe = ((w_gnt[0] & w_we[0]) | (w_gnt[1] & w_we[1])) & ~reset;

  // Saturating increment for the hold counter.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  // Next-owner decision from the current requests. The hold counter only
  // advances while the other port is waiting; an uncontested owner keeps
  // the memory indefinitely with the counter parked at zero.
  always_comb begin
    w_owner_next = r_owner;
    w_cnt_next   = r_cnt;
    w_last_next  = r_last;
    case (r_owner)
      IDLE: begin
        w_cnt_next = '0;
        if (req0 && req1) begin
          w_owner_next = r_last ? OWN0 : OWN1;
        end else if (req0) begin
          w_owner_next = OWN0;
        end else if (req1) begin
          w_owner_next = OWN1;
        end else begin
          w_owner_next = IDLE;
        end
      end
      OWN0: begin
        if (req0 && (!req1 || (r_cnt < CNT_LIMIT))) begin
          w_owner_next = OWN0;
          w_cnt_next   = req1 ? w_cnt_inc : '0;
        end else if (req1) begin
          w_owner_next = OWN1;
          w_cnt_next   = '0;
          w_last_next  = 1'b0;
        end else begin
          w_owner_next = IDLE;
          w_cnt_next   = '0;
        end
      end
      OWN1: begin
        if (req1 && (!req0 || (r_cnt < CNT_LIMIT))) begin
          w_owner_next = OWN1;
          w_cnt_next   = req0 ? w_cnt_inc : '0;
        end else if (req0) begin
          w_owner_next = OWN0;
          w_cnt_next   = '0;
          w_last_next  = 1'b1;
        end else begin
          w_owner_next = IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_owner_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Ownership state; reset leaves last=1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_owner <= w_owner_next;
      r_cnt   <= w_cnt_next;
      r_last  <= w_last_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table for reset, contention round-robin
// and streaming reads, plus hand-written sequences for write ordering,
// reset during a write, and owner release/re-request.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam logic [31:0] WD0 = 32'h0000_1111;
  localparam logic [31:0] WD1 = 32'h2222_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, we0, req1, we1;
  logic [W-1:0] adr0, wd0, adr1, wd1;
  logic         gnt0, stall0, gnt1, stall1;
  logic [W-1:0] rd0, rd1;
  logic [W-1:0] memadr, memwd, memrd;
  logic         memwe;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .HOLDMAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0),
    .gnt0(gnt0), .stall0(stall0), .rd0(rd0),
    .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1),
    .gnt1(gnt1), .stall1(stall1), .rd1(rd1),
    .memadr(memadr), .memwd(memwd), .memwe(memwe), .memrd(memrd)
  );

  // Memory model: combinational read, write on posedge.
  logic [31:0] ram [0:63];
  assign memrd = ram[memadr[7:2]];
  always @(posedge clk) begin
    if (memwe) ram[memadr[7:2]] <= memwd;
  end

  typedef struct {
    logic        rst, r0, r1;
    logic [31:0] a0, a1;
    logic        e_g0, e_g1, e_s0, e_s1, e_we;
    logic [31:0] e_adr, e_wd, e_rd;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic row(input int i, input logic rst, input logic r0, input logic r1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic g0, input logic g1);
    tbl[i].rst   = rst;
    tbl[i].r0    = r0;
    tbl[i].r1    = r1;
    tbl[i].a0    = a0;
    tbl[i].a1    = a1;
    tbl[i].e_g0  = g0;
    tbl[i].e_g1  = g1;
    tbl[i].e_s0  = r0 & ~g0;
    tbl[i].e_s1  = r1 & ~g1;
    tbl[i].e_we  = 1'b0;
    tbl[i].e_adr = g0 ? a0 : (g1 ? a1 : 32'h0);
    tbl[i].e_wd  = g0 ? WD0 : (g1 ? WD1 : 32'h0);
    tbl[i].e_rd  = 32'hA000_0000 + (tbl[i].e_adr >> 2);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; adr0 = 0; wd0 = 0;
    req1 = 0; we1 = 0; adr1 = 0; wd1 = 0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + i;
    reset = 1;
    idle_inputs();

    // Reset with both requesting, then contention round-robin (HOLDMAX=4).
    row(0, 1, 1, 1, 8, 40, 0, 0);
    row(1, 1, 1, 1, 8, 40, 0, 0);
    row(2, 0, 1, 1, 8, 40, 0, 0);
    for (int i = 3;  i <= 6;  i++) row(i, 0, 1, 1, 8, 40, 1, 0);
    for (int i = 7;  i <= 10; i++) row(i, 0, 1, 1, 8, 40, 0, 1);
    for (int i = 11; i <= 12; i++) row(i, 0, 1, 1, 8, 40, 1, 0);
    // Port 0 streaming reads from IDLE.
    row(13, 1, 0, 0, 0, 0, 0, 0);
    row(14, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 15; i <= 24; i++) row(i, 0, 1, 0, 32'(4 * (i - 15)), 0, 1, 0);
    row(25, 0, 0, 0, 36, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      tick();
      reset = tbl[i].rst;
      req0 = tbl[i].r0; we0 = 0; adr0 = tbl[i].a0; wd0 = WD0;
      req1 = tbl[i].r1; we1 = 0; adr1 = tbl[i].a1; wd1 = WD1;
      @(negedge clk);
      $display("row %0d rst=%0b req=%0b%0b gnt=%0b%0b memadr=%h rd=%h",
               i, reset, req1, req0, gnt1, gnt0, memadr, rd0);
      chk($sformatf("row%0d_gnt0", i),   {31'b0, gnt0},   {31'b0, tbl[i].e_g0});
      chk($sformatf("row%0d_gnt1", i),   {31'b0, gnt1},   {31'b0, tbl[i].e_g1});
      chk($sformatf("row%0d_stall0", i), {31'b0, stall0}, {31'b0, tbl[i].e_s0});
      chk($sformatf("row%0d_stall1", i), {31'b0, stall1}, {31'b0, tbl[i].e_s1});
      chk($sformatf("row%0d_memwe", i),  {31'b0, memwe},  {31'b0, tbl[i].e_we});
      chk($sformatf("row%0d_memadr", i), memadr, tbl[i].e_adr);
      chk($sformatf("row%0d_memwd", i),  memwd,  tbl[i].e_wd);
      if (tbl[i].e_g0) chk($sformatf("row%0d_rd0", i), rd0, tbl[i].e_rd);
      if (tbl[i].e_g1) chk($sformatf("row%0d_rd1", i), rd1, tbl[i].e_rd);
    end

    // Port 1 writes 84 while port 0 waits to read the same address.
    tick(); reset = 1; idle_inputs();
    tick(); reset = 0; req1 = 1; we1 = 1; adr1 = 84; wd1 = 32'hDEADBEEF;
    @(negedge clk);
    $display("wr_idle gnt=%0b%0b memwe=%0b", gnt1, gnt0, memwe);
    chk("wr_idle_gnt1", {31'b0, gnt1}, 32'd0);
    chk("wr_idle_memwe", {31'b0, memwe}, 32'd0);
    tick(); req0 = 1; adr0 = 84;
    @(negedge clk);
    $display("wr_grant gnt=%0b%0b memwe=%0b memadr=%h", gnt1, gnt0, memwe, memadr);
    chk("wr_gnt1", {31'b0, gnt1}, 32'd1);
    chk("wr_gnt0", {31'b0, gnt0}, 32'd0);
    chk("wr_stall0", {31'b0, stall0}, 32'd1);
    chk("wr_memwe", {31'b0, memwe}, 32'd1);
    chk("wr_memadr", memadr, 32'd84);
    chk("wr_memwd", memwd, 32'hDEADBEEF);
    tick(); req1 = 0; we1 = 0;
    @(negedge clk);
    $display("wr_release gnt=%0b%0b memwe=%0b", gnt1, gnt0, memwe);
    chk("wr_rel_gnt0", {31'b0, gnt0}, 32'd0);
    chk("wr_rel_memwe", {31'b0, memwe}, 32'd0);
    tick();
    @(negedge clk);
    $display("rd_after_wr gnt0=%0b rd0=%h", gnt0, rd0);
    chk("rdw_gnt0", {31'b0, gnt0}, 32'd1);
    chk("rdw_memwe", {31'b0, memwe}, 32'd0);
    chk("rdw_rd0", rd0, 32'hDEADBEEF);

    // Reset lands on an OWN1 write cycle.
    tick(); reset = 1; idle_inputs();
    tick(); reset = 0; req1 = 1; we1 = 1; adr1 = 104; wd1 = 32'hCAFEF00D;
    tick(); reset = 1;
    @(negedge clk);
    $display("rst_wr gnt1=%0b memwe=%0b", gnt1, memwe);
    chk("rstwr_memwe", {31'b0, memwe}, 32'd0);
    chk("rstwr_gnt1", {31'b0, gnt1}, 32'd0);
    chk("rstwr_stall1", {31'b0, stall1}, 32'd1);
    chk("rstwr_memadr", memadr, 32'd0);
    tick(); reset = 0;
    @(negedge clk);
    $display("rst_after gnt1=%0b ram26=%h", gnt1, ram[26]);
    chk("rstaft_gnt1_idle", {31'b0, gnt1}, 32'd0);
    chk("rstaft_memwe", {31'b0, memwe}, 32'd0);
    chk("rstaft_ram", ram[26], 32'hA000_001A);
    tick(); req1 = 0; we1 = 0;
    @(negedge clk);
    chk("rstaft2_memwe", {31'b0, memwe}, 32'd0);

    // Owner drops request for one cycle with the other port idle.
    tick(); reset = 1; idle_inputs();
    tick(); reset = 0; req0 = 1; adr0 = 12;
    @(negedge clk);
    $display("drop_start gnt0=%0b stall0=%0b", gnt0, stall0);
    chk("drop_idle_gnt0", {31'b0, gnt0}, 32'd0);
    chk("drop_idle_stall0", {31'b0, stall0}, 32'd1);
    tick();
    @(negedge clk);
    $display("drop_grant gnt0=%0b rd0=%h", gnt0, rd0);
    chk("drop_g1_gnt0", {31'b0, gnt0}, 32'd1);
    chk("drop_g1_rd0", rd0, 32'hA000_0003);
    chk("drop_g1_memwe", {31'b0, memwe}, 32'd0);
    tick(); req0 = 0;
    @(negedge clk);
    $display("drop_released gnt0=%0b memwe=%0b", gnt0, memwe);
    chk("drop_off_gnt0", {31'b0, gnt0}, 32'd0);
    chk("drop_off_memwe", {31'b0, memwe}, 32'd0);
    tick(); req0 = 1;
    @(negedge clk);
    $display("drop_rereq gnt0=%0b stall0=%0b", gnt0, stall0);
    chk("drop_idle2_gnt0", {31'b0, gnt0}, 32'd0);
    chk("drop_idle2_stall0", {31'b0, stall0}, 32'd1);
    chk("drop_idle2_memwe", {31'b0, memwe}, 32'd0);
    tick();
    @(negedge clk);
    $display("drop_regrant gnt0=%0b", gnt0);
    chk("drop_regrant_gnt0", {31'b0, gnt0}, 32'd1);
    chk("drop_regrant_memwe", {31'b0, memwe}, 32'd0);
    tick(); req0 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
